mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 32-bit memory port between the instruction fetch unit
//  (fetch, FETCH_IMM and FETCH_IMEM reads) and the load/store path. It
//  arbitrates, registers one transaction at a time onto the memory bus and
//  returns the response. It also masks data by size, bounds latency with a
//  timeout and keeps the fetch unit from starving.
// PARAMETERS
//  STREAK_MAX   4    max consecutive LS grants while IF waits (1..15)
//  TIMEOUT      255  cycles of mem_req without mem_ack before abort (0=off, max 255)
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   reset, asynchronous, active-low
//  if_req     in   1   fetch request; held with if_addr/if_size until if_rvalid
//  if_addr    in   32  fetch byte address (no alignment requirement)
//  if_size    in   2   00 byte, 01 half, 10 word, 11 illegal
//  if_gnt     out  1   1-cycle pulse: fetch request accepted
//  if_rvalid  out  1   1-cycle pulse: if_rdata/if_err valid
//  if_rdata   out  32  read data, zero-extended per if_size
//  if_err     out  1   bus error, timeout or illegal size (valid with if_rvalid)
//  ls_req     in   1   load/store request; held with ls_* until ls_rvalid
//  ls_we      in   1   1 store, 0 load
//  ls_addr    in   32  data byte address
//  ls_size    in   2   as if_size
//  ls_wdata   in   32  store data, low bytes significant
//  ls_gnt / ls_rvalid / ls_rdata / ls_err  out  1/1/32/1  as if_* for LS
//  mem_req    out  1   memory request, registered
//  mem_we     out  1   write enable
//  mem_addr   out  32  address
//  mem_size   out  2   access size
//  mem_wdata  out  32  write data, bits above size forced 0
//  mem_ack    in   1   memory completes the current request
//  mem_rdata  in   32  read data, sampled with mem_ack
//  mem_err    in   1   memory error, sampled with mem_ack
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; all outputs 0; streak and timer 0.
//    A transaction in flight is dropped with no rvalid. mem_req falls at once.
//  - FSM IDLE -> BUSY -> RESP -> IDLE. Only one transaction outstanding.
//  - IDLE, combinational arbitration: LS wins if both requests are high and
//    streak < STREAK_MAX, else IF wins. Winner gets gnt pulse that cycle and
//    its addr/size/we/wdata are latched. IF's mem_we is 0. Next state BUSY.
//  - Illegal size (11) on the winner: still gnt. The transaction never enters
//    BUSY and goes straight to RESP with err=1, rdata=0, mem_req stays 0.
//  - BUSY: mem_req=1 with latched fields stable. On mem_ack, capture
//    mem_rdata (zero-extended: byte [7:0], half [15:0]) and mem_err, go to
//    RESP. Stores return rdata=0.
//  - Timeout: timer counts BUSY cycles. If TIMEOUT!=0 and the timer reaches
//    TIMEOUT without mem_ack, go to RESP with err=1, rdata=0. mem_req drops
//    in RESP.
//  - RESP: owner's rvalid=1 for exactly one cycle, other requester's rvalid=0.
//    Next state IDLE. New gnt no earlier than the cycle after RESP.
//  - Latency: gnt in cycle 0, mem_req cycles 1..k (ack in k), rvalid k+1,
//    next gnt >= k+2. Zero-wait memory (ack in cycle 1) gives 3 cycles/access.
//  - Streak counter (4 bit): +1 on an LS grant while if_req=1 (saturates);
//    cleared on an IF grant or any IDLE cycle with if_req=0.
//  - mem_ack in IDLE or RESP is ignored (stale), with no state change.
//  - A requester dropping req before rvalid is a protocol violation. The
//    access still completes and rvalid still pulses.
//  - Outputs rdata/err hold their value after rvalid until the next RESP.
// TESTING
//  1 Reset mid-BUSY: LS load in flight, rst=0 -> mem_req=0 in the same cycle,
//    no ls_rvalid, busy=0.
//  2 IF fetch, addr 0x100, size 10, mem_ack in cycle 2 with rdata
//    0xDEADBEEF -> if_gnt c0, mem_req c1-2, if_rvalid c3, if_rdata 0xDEADBEEF.
//  3 Both requesting continuously, STREAK_MAX=4 -> grant order LS,LS,LS,LS,
//    IF,LS,... IF is never starved.
//  4 LS store size 00, wdata 0x12345678 -> mem_wdata 0x00000078, mem_we=1.
//    Load size 01 with mem_rdata 0xAABBCCDD -> ls_rdata 0x0000CCDD.
//  5 TIMEOUT=8 with mem_ack held 0 -> mem_req high 8 cycles, then
//    ls_err=1 with rdata=0, FSM back in IDLE.
//  6 if_size=11 -> if_gnt, mem_req never high, if_rvalid next cycle with
//    if_err=1. A stray mem_ack in IDLE causes no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch unit, the load/store path, the memory port
// and the arbiter that shares that port between the two requesters.
interface mem_port_arbiter_if;
    // Instruction fetch requester
    logic        if_req;
    logic [31:0] if_addr;
    logic [1:0]  if_size;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    // Load/store requester
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [1:0]  ls_size;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;

    // Shared memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    // Arbiter view: serves both requesters and drives the memory port
    modport slave (
        input  if_req, if_addr, if_size,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_req, ls_we, ls_addr, ls_size, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_req, mem_we, mem_addr, mem_size, mem_wdata,
        input  mem_ack, mem_rdata, mem_err
    );

    // Environment view: the requesters plus the memory itself
    modport master (
        output if_req, if_addr, if_size,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output ls_req, ls_we, ls_addr, ls_size, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_req, mem_we, mem_addr, mem_size, mem_wdata,
        output mem_ack, mem_rdata, mem_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and load/store.
// One transaction is outstanding at a time: IDLE grants, BUSY holds the
// registered request on the bus, RESP returns data to the owner for a cycle.
// A streak counter stops load/store from starving fetch, and a BUSY timer
// aborts accesses the memory never acknowledges.
module mem_port_arbiter #(
    parameter int unsigned STREAK_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_port_arbiter_if.slave bus,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] STREAK_LIMIT  = 4'(STREAK_MAX);
    localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  timer_q, timer_d;
    logic [3:0]  streak_q, streak_d;
    logic [31:0] ifRdata_q, ifRdata_d;
    logic        ifErr_q, ifErr_d;
    logic [31:0] lsRdata_q, lsRdata_d;
    logic        lsErr_q, lsErr_d;

    logic        grantIf, grantLs;
    logic        selWe;
    logic [31:0] selAddr;
    logic [1:0]  selSize;
    logic [31:0] selWdata;
    logic        complete;
    logic [31:0] compRdata;
    logic        compErr;

    // Bytes that carry meaning for a given access size; illegal size keeps none
    function automatic logic [31:0] sizeMask(input logic [1:0] size);
        case (size)
            2'b00:   sizeMask = 32'h0000_00FF;
            2'b01:   sizeMask = 32'h0000_FFFF;
            2'b10:   sizeMask = 32'hFFFF_FFFF;
            default: sizeMask = 32'h0000_0000;
        endcase
    endfunction

    // Arbitration in IDLE: load/store wins ties until its streak hits the limit
    always_comb begin
        grantLs = 1'b0;
        grantIf = 1'b0;
        if (state_q == IDLE) begin
            if (bus.ls_req && (!bus.if_req || (streak_q < STREAK_LIMIT))) begin
                grantLs = 1'b1;
            end else if (bus.if_req) begin
                grantIf = 1'b1;
            end
        end
    end

    // Fields of the winning requester; fetch never writes and loads carry no data
    always_comb begin
        selAddr  = grantLs ? bus.ls_addr : bus.if_addr;
        selSize  = grantLs ? bus.ls_size : bus.if_size;
        selWe    = grantLs & bus.ls_we;
        selWdata = selWe ? (bus.ls_wdata & sizeMask(selSize)) : 32'h0;
    end

    // Next state, transaction latching, completion capture and streak/timer upkeep
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        timer_d   = timer_q;
        streak_d  = streak_q;
        ifRdata_d = ifRdata_q;
        ifErr_d   = ifErr_q;
        lsRdata_d = lsRdata_q;
        lsErr_d   = lsErr_q;
        complete  = 1'b0;
        compRdata = 32'h0;
        compErr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.if_req) begin
                    streak_d = 4'd0;
                end
                if (grantLs || grantIf) begin
                    owner_d = grantLs;
                    we_d    = selWe;
                    addr_d  = selAddr;
                    size_d  = selSize;
                    wdata_d = selWdata;
                    timer_d = 8'd0;
                    if (grantIf) begin
                        streak_d = 4'd0;
                    end else if (bus.if_req && (streak_q != 4'hF)) begin
                        streak_d = streak_q + 4'd1;
                    end
                    if (selSize == 2'b11) begin
                        state_d  = RESP;
                        complete = 1'b1;
                        compErr  = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (timer_q != 8'hFF) begin
                    timer_d = timer_q + 8'd1;
                end
                if (bus.mem_ack) begin
                    state_d   = RESP;
                    complete  = 1'b1;
                    compRdata = we_q ? 32'h0 : (bus.mem_rdata & sizeMask(size_q));
                    compErr   = bus.mem_err;
                end else if ((TIMEOUT_LIMIT != 9'd0) &&
                             (({1'b0, timer_q} + 9'd1) == TIMEOUT_LIMIT)) begin
                    state_d  = RESP;
                    complete = 1'b1;
                    compErr  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (complete) begin
            if (owner_d) begin
                lsRdata_d = compRdata;
                lsErr_d   = compErr;
            end else begin
                ifRdata_d = compRdata;
                ifErr_d   = compErr;
            end
        end
    end

    // State register; reset drops any transaction in flight without a response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            size_q    <= 2'b00;
            wdata_q   <= 32'h0;
            timer_q   <= 8'd0;
            streak_q  <= 4'd0;
            ifRdata_q <= 32'h0;
            ifErr_q   <= 1'b0;
            lsRdata_q <= 32'h0;
            lsErr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            timer_q   <= timer_d;
            streak_q  <= streak_d;
            ifRdata_q <= ifRdata_d;
            ifErr_q   <= ifErr_d;
            lsRdata_q <= lsRdata_d;
            lsErr_q   <= lsErr_d;
        end
    end

    assign bus.if_gnt    = grantIf;
    assign bus.ls_gnt    = grantLs;
    assign bus.if_rvalid = (state_q == RESP) && !owner_q;
    assign bus.ls_rvalid = (state_q == RESP) && owner_q;
    assign bus.if_rdata  = ifRdata_q;
    assign bus.if_err    = ifErr_q;
    assign bus.ls_rdata  = lsRdata_q;
    assign bus.ls_err    = lsErr_q;
    assign bus.mem_req   = (state_q == BUSY);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_size  = size_q;
    assign bus.mem_wdata = wdata_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus pushes the expected response
// of every granted access into a queue; a negedge monitor pops and compares
// whenever either rvalid pulses.
module tb_mem_port_arbiter;

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    logic busy;

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .STREAK_MAX(4),
        .TIMEOUT   (8)
    ) dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus),
        .busy_o(busy)
    );

    typedef struct packed {
        logic        isLs;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t expQ[$];
    resp_t monExp;
    int    testsRun    = 0;
    int    testsFailed = 0;

    // One comparison, one FAIL line when it disagrees
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, 32'(actual), 32'(expected));
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic [1:0] ifSize, input logic lsReq,
                                 input logic lsWe, input logic [31:0] lsAddr,
                                 input logic [1:0] lsSize, input logic [31:0] lsWdata);
        bus.if_req   = ifReq;
        bus.if_addr  = ifAddr;
        bus.if_size  = ifSize;
        bus.ls_req   = lsReq;
        bus.ls_we    = lsWe;
        bus.ls_addr  = lsAddr;
        bus.ls_size  = lsSize;
        bus.ls_wdata = lsWdata;
    endtask

    task automatic driveMem(input logic ack, input logic [31:0] rdata, input logic err);
        bus.mem_ack   = ack;
        bus.mem_rdata = rdata;
        bus.mem_err   = err;
    endtask

    task automatic expectResp(input logic isLs, input logic [31:0] rdata, input logic err);
        resp_t r;
        r.isLs  = isLs;
        r.rdata = rdata;
        r.err   = err;
        expQ.push_back(r);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Single access: grant in c0, waitCycles of mem_req (ack in the last one
    // if ackIt), response in the following cycle, then back to IDLE.
    task automatic runAccess(input string tag, input logic isLs, input logic we,
                             input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata, input int waitCycles,
                             input logic ackIt, input logic [31:0] memRdata,
                             input logic memErr, input logic chkWdata,
                             input logic [31:0] expWdata, input logic [31:0] expRdata,
                             input logic expErr);
        nextCycle();
        if (isLs) applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, we, addr, size, wdata);
        else      applyStimulus(1'b1, addr, size, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        expectResp(isLs, expRdata, expErr);
        sample();
        checkBit({tag, "_gnt"}, isLs ? bus.ls_gnt : bus.if_gnt, 1'b1);
        checkBit({tag, "_other_gnt"}, isLs ? bus.if_gnt : bus.ls_gnt, 1'b0);
        checkBit({tag, "_mem_req_c0"}, bus.mem_req, 1'b0);
        for (int i = 1; i <= waitCycles; i++) begin
            nextCycle();
            driveMem(ackIt && (i == waitCycles), memRdata, memErr);
            sample();
            checkBit($sformatf("%s_mem_req_c%0d", tag, i), bus.mem_req, 1'b1);
            checkBit({tag, "_mem_we"}, bus.mem_we, we);
            checkOutput({tag, "_mem_addr"}, bus.mem_addr, addr);
            checkOutput({tag, "_mem_size"}, 32'(bus.mem_size), 32'(size));
            if (chkWdata) checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, expWdata);
        end
        nextCycle();
        driveMem(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        sample();
        checkBit({tag, "_rvalid"}, isLs ? bus.ls_rvalid : bus.if_rvalid, 1'b1);
        checkBit({tag, "_mem_req_resp"}, bus.mem_req, 1'b0);
        nextCycle();
        sample();
        checkBit({tag, "_idle_after"}, busy, 1'b0);
        checkBit({tag, "_rvalid_once"}, isLs ? bus.ls_rvalid : bus.if_rvalid, 1'b0);
    endtask

    // Scoreboard monitor: every rvalid pops one expected response
    always @(negedge clk) begin
        if (rstN && (bus.if_rvalid || bus.ls_rvalid)) begin
            checkBit("rvalid_exclusive", bus.if_rvalid & bus.ls_rvalid, 1'b0);
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_rvalid: got if_rvalid=%0b ls_rvalid=%0b, expected none",
                         bus.if_rvalid, bus.ls_rvalid);
            end else begin
                monExp = expQ.pop_front();
                checkBit("resp_owner_ls", bus.ls_rvalid, monExp.isLs);
                checkOutput("resp_rdata", monExp.isLs ? bus.ls_rdata : bus.if_rdata, monExp.rdata);
                checkBit("resp_err", monExp.isLs ? bus.ls_err : bus.if_err, monExp.err);
            end
        end
    end

    logic expIsLs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int   grantIdx;
    logic done;

    // Directed test sequence
    initial begin
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        driveMem(1'b0, 32'h0, 1'b0);
        #1 rstN = 1'b0;
        #2;
        checkBit("reset_mem_req", bus.mem_req, 1'b0);
        checkBit("reset_busy", busy, 1'b0);
        checkBit("reset_if_rvalid", bus.if_rvalid, 1'b0);
        checkBit("reset_ls_rvalid", bus.ls_rvalid, 1'b0);
        checkOutput("reset_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("reset_ls_rdata", bus.ls_rdata, 32'h0);
        nextCycle();
        nextCycle();
        rstN = 1'b1;

        // Word fetch with one wait state, response data held afterwards
        runAccess("fetch_word", 1'b0, 1'b0, 32'h100, 2'b10, 32'h0, 2, 1'b1,
                  32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        checkOutput("fetch_rdata_hold", bus.if_rdata, 32'hDEADBEEF);

        // Byte store masks write data; store response carries no data
        runAccess("store_byte", 1'b1, 1'b1, 32'h200, 2'b00, 32'h12345678, 1, 1'b1,
                  32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000078, 32'h0, 1'b0);
        // Half load is zero-extended
        runAccess("load_half", 1'b1, 1'b0, 32'h202, 2'b01, 32'h0, 1, 1'b1,
                  32'hAABBCCDD, 1'b0, 1'b0, 32'h0, 32'h0000CCDD, 1'b0);
        // Byte fetch with a bus error
        runAccess("fetch_byte_err", 1'b0, 1'b0, 32'h103, 2'b00, 32'h0, 1, 1'b1,
                  32'h11223344, 1'b1, 1'b0, 32'h0, 32'h00000044, 1'b1);

        // Illegal size skips the bus and errors at once
        runAccess("fetch_illegal", 1'b0, 1'b0, 32'h300, 2'b11, 32'h0, 0, 1'b0,
                  32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        // Stray ack in IDLE changes nothing
        driveMem(1'b1, 32'hCAFEF00D, 1'b1);
        sample();
        checkBit("stray_ack_busy", busy, 1'b0);
        nextCycle();
        driveMem(1'b0, 32'h0, 1'b0);
        sample();
        checkBit("stray_ack_busy_next", busy, 1'b0);
        checkBit("stray_ack_mem_req", bus.mem_req, 1'b0);

        // Memory never answers: aborted after eight request cycles
        runAccess("load_timeout", 1'b1, 1'b0, 32'h400, 2'b10, 32'h0, 8, 1'b0,
                  32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Both requesters hold req continuously against a zero-wait memory
        grantIdx = 0;
        done     = 1'b0;
        driveMem(1'b0, 32'h00001234, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'h500, 2'b10, 1'b1, 1'b0, 32'h600, 2'b10, 32'h0);
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            bus.mem_ack = bus.mem_req;
            sample();
            if ((bus.if_gnt || bus.ls_gnt) && grantIdx < 6) begin
                checkBit($sformatf("grant_order_%0d", grantIdx), bus.ls_gnt, expIsLs[grantIdx]);
                expectResp(expIsLs[grantIdx], 32'h00001234, 1'b0);
                grantIdx++;
            end else if (grantIdx == 6 && (bus.if_rvalid || bus.ls_rvalid)) begin
                applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
                done = 1'b1;
            end
            if (!done) nextCycle();
        end
        if (!done) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL streak_budget: got %0d grants, expected 6 within 60 cycles", grantIdx);
            applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        end
        nextCycle();
        driveMem(1'b0, 32'h0, 1'b0);
        nextCycle();

        // Reset while a load is on the bus: dropped, no response
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h700, 2'b10, 32'h0);
        sample();
        checkBit("rst_mid_gnt", bus.ls_gnt, 1'b1);
        nextCycle();
        sample();
        checkBit("rst_mid_mem_req_before", bus.mem_req, 1'b1);
        nextCycle();
        rstN = 1'b0;
        #1;
        checkBit("rst_mid_mem_req", bus.mem_req, 1'b0);
        checkBit("rst_mid_busy", busy, 1'b0);
        checkBit("rst_mid_ls_rvalid", bus.ls_rvalid, 1'b0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        nextCycle();
        nextCycle();
        rstN = 1'b1;
        nextCycle();
        nextCycle();

        // Arbiter serves normally after the reset
        runAccess("post_reset_fetch", 1'b0, 1'b0, 32'h800, 2'b10, 32'h0, 1, 1'b1,
                  32'h0BADF00D, 1'b0, 1'b0, 32'h0, 32'h0BADF00D, 1'b0);

        nextCycle();
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
